// File: rtl/pc_predict_unit_pkg.sv
// Shared constants for the fetch-stage next-PC unit: branch opcodes, condition
// codes, flag bit positions and direction-counter values.
package pc_predict_unit_pkg;

  localparam logic [3:0] OP_B  = 4'b1100;
  localparam logic [3:0] OP_BR = 4'b1101;

  typedef enum logic [2:0] {
    NEQ    = 3'b000,
    EQ     = 3'b001,
    GT     = 3'b010,
    LT     = 3'b011,
    GTEQ   = 3'b100,
    LTEQ   = 3'b101,
    OVFL   = 3'b110,
    ALWAYS = 3'b111
  } cond_e;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  localparam logic [1:0] CTR_MIN   = 2'b00;
  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;
  localparam logic [1:0] CTR_MAX   = 2'b11;

  function automatic logic cond_met(input cond_e c, input logic [2:0] f);
    logic z, v, n, res;
    z   = f[FLAG_Z];
    v   = f[FLAG_V];
    n   = f[FLAG_N];
    res = 1'b0;
    case (c)
      NEQ:     res = ~z;
      EQ:      res = z;
      GT:      res = ~(z | n);
      LT:      res = n;
      GTEQ:    res = ~n;
      LTEQ:    res = z | n;
      OVFL:    res = v;
      ALWAYS:  res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Storage exists only when PC_PREDICT_BTB_EN is defined; otherwise static not-taken.
module pc_btb
  import pc_predict_unit_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int BTB_ENTRIES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_en,
  input  logic              upd_is_branch,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target
);

  logic [ADDR_W-1:0] seq_pc;
  assign seq_pc = lookup_pc + ADDR_W'(2);

`ifdef PC_PREDICT_BTB_EN
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - 1 - IDX_W;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [1:0]             ctr_q    [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [ADDR_W-1:0]      target_q [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit;
  logic             unused_lsb;

  assign rd_idx = lookup_pc[IDX_W:1];
  assign rd_tag = lookup_pc[ADDR_W-1:IDX_W+1];
  assign wr_idx = upd_pc[IDX_W:1];
  assign wr_tag = upd_pc[ADDR_W-1:IDX_W+1];
  assign unused_lsb = lookup_pc[0] ^ upd_pc[0];

  assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign wr_hit      = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  assign pred_taken  = rd_hit & ctr_q[rd_idx][1];
  assign pred_target = pred_taken ? target_q[rd_idx] : seq_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) ctr_q[i] <= CTR_RESET;
    end else if (upd_en) begin
      if (!upd_is_branch) begin
        // a non-branch that hits means the entry aliased; drop it
        if (wr_hit) valid_q[wr_idx] <= 1'b0;
      end else if (wr_hit) begin
        if (upd_taken) begin
          if (ctr_q[wr_idx] != CTR_MAX) ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'd1;
        end else if (ctr_q[wr_idx] != CTR_MIN) begin
          ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_q[wr_idx] <= 1'b1;
        ctr_q[wr_idx]   <= CTR_ALLOC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && upd_en && upd_is_branch && upd_taken) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= upd_target;
    end
  end
`else
  localparam int unused_entries = BTB_ENTRIES;
  logic unused_btb;

  assign pred_taken  = 1'b0;
  assign pred_target = seq_pc;
  assign unused_btb  = ^{clk, rst, upd_en, upd_is_branch, upd_taken, upd_pc, upd_target};
`endif

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-stage PC register, next-PC prediction and ID-stage branch resolution.
// PC_PREDICT_BTB_EN enables the BTB; without it every fetch is predicted not-taken.
module pc_predict_unit
  import pc_predict_unit_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                INSTR_W     = 16,
  parameter int                BTB_ENTRIES = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt,
  input  logic               stall,
  input  logic               id_valid,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic [ADDR_W-1:0]  id_pc,
  input  logic               id_pred_taken,
  input  logic [ADDR_W-1:0]  id_pred_target,
  input  logic [ADDR_W-1:0]  br_addr,
  input  logic [2:0]         flags,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               if_pred_taken,
  output logic [ADDR_W-1:0]  if_pred_target,
  output logic               flush,
  output logic [15:0]        mispredict_cnt
);

  logic [3:0]        opcode;
  cond_e             cond;
  logic [8:0]        imm;
  logic              is_b, is_br, is_branch, taken, mispredict;
  logic [ADDR_W-1:0] id_seq_pc, b_offset, b_target, actual_target;

  assign opcode    = id_instr[15:12];
  assign cond      = cond_e'(id_instr[11:9]);
  assign imm       = id_instr[8:0];
  assign is_b      = (opcode == OP_B);
  assign is_br     = (opcode == OP_BR);
  assign is_branch = is_b | is_br;
  assign taken     = is_branch & cond_met(cond, flags);

  assign id_seq_pc     = id_pc + ADDR_W'(2);
  assign b_offset      = ADDR_W'($signed(imm)) << 1;
  assign b_target      = id_seq_pc + b_offset;
  assign actual_target = is_br ? br_addr : b_target;

  // non-branches resolve as not-taken, so an aliased taken prediction mispredicts
  assign mispredict = id_valid &
                      ((taken != id_pred_taken) | (taken & (id_pred_target != actual_target)));
  assign flush      = mispredict & ~halt & ~rst;

  pc_btb #(
    .ADDR_W      (ADDR_W),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc     (if_pc),
    .pred_taken    (if_pred_taken),
    .pred_target   (if_pred_target),
    .upd_en        (id_valid & ~halt),
    .upd_is_branch (is_branch),
    .upd_taken     (taken),
    .upd_pc        (id_pc),
    .upd_target    (actual_target)
  );

  // redirect outranks stall so the squashed slot is never refetched
  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc <= RESET_PC;
    end else if (!halt) begin
      if (mispredict) if_pc <= taken ? actual_target : id_seq_pc;
      else if (!stall) if_pc <= if_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_cnt <= '0;
    end else if (flush && (mispredict_cnt != 16'hFFFF)) begin
      mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Self-checking bench for pc_predict_unit: directed sequences, a vector table and
// randomized traffic checked against an array-based reference model.
module tb_pc_predict_unit;
  import pc_predict_unit_pkg::*;

`ifdef PC_PREDICT_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, halt, stall, id_valid, id_pred_taken;
  logic [15:0] id_instr, id_pc, id_pred_target, br_addr;
  logic [2:0]  flags;
  logic [15:0] if_pc, if_pred_target, mispredict_cnt;
  logic        if_pred_taken, flush;

  pc_predict_unit #(
    .ADDR_W(16), .INSTR_W(16), .BTB_ENTRIES(8), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .halt(halt), .stall(stall), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_pred_taken(id_pred_taken),
    .id_pred_target(id_pred_target), .br_addr(br_addr), .flags(flags),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .flush(flush), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_pc, m_cnt;
  bit m_valid [8];
  int m_ctr [8];
  int m_tag [8];
  int m_tgt [8];

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  c;
    logic [2:0]  f;
    logic [8:0]  imm;
    logic        ef;
    logic [15:0] epc;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] c, input logic [8:0] imm);
    return {op, c, imm};
  endfunction

  function automatic bit m_cond(input int c, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      0: return !z;
      1: return z;
      2: return !(z || n);
      3: return n;
      4: return !n;
      5: return z || n;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic void m_resolve(output bit isb, output bit tk, output int act);
    int op, imm;
    op  = int'(id_instr[15:12]);
    imm = int'(id_instr[8:0]);
    if (imm >= 256) imm -= 512;
    isb = (op == 12) || (op == 13);
    tk  = isb && m_cond(int'(id_instr[11:9]), flags);
    act = (op == 13) ? int'(br_addr) : ((int'(id_pc) + 2 + imm * 2) & 'hFFFF);
  endfunction

  function automatic void m_lookup(input int pc, output bit pt, output int tgt);
    int idx, tag;
    idx = (pc >> 1) & 7;
    tag = pc >> 4;
    pt  = BTB_ON && m_valid[idx] && (m_tag[idx] == tag) && (m_ctr[idx] >= 2);
    tgt = pt ? m_tgt[idx] : ((pc + 2) & 'hFFFF);
  endfunction

  // Called after inputs have settled; checks outputs, advances the model, runs one clock.
  task automatic cycle(input bit do_chk);
    bit pt, isb, tk, misp, fl;
    int tgt, act, idx, tag;
    m_lookup(m_pc, pt, tgt);
    m_resolve(isb, tk, act);
    misp = id_valid && ((tk != id_pred_taken) || (tk && (int'(id_pred_target) != act)));
    fl   = misp && !halt && !rst;
    if (do_chk) begin
      chk("if_pc", if_pc, m_pc);
      chk("if_pred_taken", if_pred_taken, pt);
      chk("if_pred_target", if_pred_target, tgt);
      chk("flush", flush, fl);
      chk("mispredict_cnt", mispredict_cnt, m_cnt);
    end
    idx = (int'(id_pc) >> 1) & 7;
    tag = int'(id_pc) >> 4;
    if (rst) begin
      m_pc  = 0;
      m_cnt = 0;
      foreach (m_valid[i]) begin m_valid[i] = 0; m_ctr[i] = 1; end
    end else begin
      if (fl && m_cnt < 'hFFFF) m_cnt++;
      if (id_valid && !halt) begin
        if (m_valid[idx] && m_tag[idx] == tag) begin
          if (!isb) m_valid[idx] = 0;
          else if (tk) begin
            if (m_ctr[idx] < 3) m_ctr[idx]++;
            m_tgt[idx] = act;
          end else if (m_ctr[idx] > 0) m_ctr[idx]--;
        end else if (isb && tk) begin
          m_valid[idx] = 1; m_tag[idx] = tag; m_tgt[idx] = act; m_ctr[idx] = 2;
        end
      end
      if (!halt) begin
        if (misp) m_pc = tk ? act : ((int'(id_pc) + 2) & 'hFFFF);
        else if (!stall) m_pc = tgt;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go(input bit do_chk);
    #1;
    cycle(do_chk);
  endtask

  task automatic idle();
    rst = 0; halt = 0; stall = 0; id_valid = 0;
    id_instr = 16'h0; id_pc = 16'h0; id_pred_taken = 0; id_pred_target = 16'h0;
    br_addr = 16'h0; flags = 3'b000;
  endtask

  task automatic redirect_to(input logic [15:0] pc);
    idle();
    id_valid = 1; id_instr = mk(4'h0, 3'b000, 9'h0); id_pc = pc - 16'd2;
    id_pred_taken = 1; id_pred_target = 16'h0050;
    go(1);
    idle();
  endtask

  initial begin
    bit isb, tk;
    int act, r;
    logic [3:0] op;

    tbl[0]  = '{OP_B,  3'b000, 3'b000, 9'h004, 1'b1, 16'h010A};
    tbl[1]  = '{OP_B,  3'b000, 3'b100, 9'h004, 1'b0, 16'h0000};
    tbl[2]  = '{OP_B,  3'b001, 3'b100, 9'h1FE, 1'b1, 16'h00FE};
    tbl[3]  = '{OP_B,  3'b010, 3'b001, 9'h004, 1'b0, 16'h0000};
    tbl[4]  = '{OP_B,  3'b010, 3'b010, 9'h000, 1'b1, 16'h0102};
    tbl[5]  = '{OP_B,  3'b011, 3'b001, 9'h100, 1'b1, 16'hFF02};
    tbl[6]  = '{OP_BR, 3'b100, 3'b001, 9'h000, 1'b0, 16'h0000};
    tbl[7]  = '{OP_BR, 3'b100, 3'b000, 9'h000, 1'b1, 16'h0200};
    tbl[8]  = '{OP_BR, 3'b101, 3'b100, 9'h000, 1'b1, 16'h0200};
    tbl[9]  = '{OP_BR, 3'b101, 3'b010, 9'h000, 1'b0, 16'h0000};
    tbl[10] = '{OP_B,  3'b110, 3'b010, 9'h0FF, 1'b1, 16'h0300};
    tbl[11] = '{OP_B,  3'b110, 3'b101, 9'h004, 1'b0, 16'h0000};
    tbl[12] = '{4'h0,  3'b111, 3'b111, 9'h004, 1'b0, 16'h0000};
    tbl[13] = '{OP_BR, 3'b111, 3'b000, 9'h000, 1'b1, 16'h0200};

    idle();
    rst = 1;
    go(0);
    go(1);
    idle();

    // free-running from reset
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("free_pc", if_pc, 32'(2 * i));
      chk("free_pred_taken", if_pred_taken, 0);
      chk("free_flush", flush, 0);
      cycle(1);
    end

    // B always-taken, predicted not-taken
    id_valid = 1; id_instr = mk(OP_B, 3'b111, 9'h004); id_pc = 16'h0010;
    #1;
    chk("b_alloc_flush", flush, 1);
    cycle(1);
    chk("b_alloc_pc", if_pc, 16'h001A);

    redirect_to(16'h0010);
    chk("refetch_pc", if_pc, 16'h0010);
    id_valid = 1; id_instr = mk(OP_B, 3'b111, 9'h004); id_pc = 16'h0010;
    id_pred_taken = 1; id_pred_target = 16'h001A;
    #1;
    chk("refetch_pred_taken", if_pred_taken, BTB_ON);
    chk("refetch_pred_target", if_pred_target, BTB_ON ? 16'h001A : 16'h0012);
    chk("refetch_flush", flush, 0);
    cycle(1);

    // BR not taken (Z=0, EQ) while predicted taken, twice: counter walks down
    idle();
    id_valid = 1; id_instr = mk(OP_BR, 3'b001, 9'h0); id_pc = 16'h0010;
    id_pred_taken = 1; id_pred_target = 16'h001A;
    #1;
    chk("br_nt_flush", flush, 1);
    cycle(1);
    chk("br_nt_pc", if_pc, 16'h0012);
    redirect_to(16'h0010);
    id_valid = 1; id_instr = mk(OP_BR, 3'b001, 9'h0); id_pc = 16'h0010;
    id_pred_taken = 1; id_pred_target = 16'h001A;
    #1;
    chk("ctr2_pred_taken", if_pred_taken, BTB_ON);
    cycle(1);
    redirect_to(16'h0010);
    #1;
    chk("ctr1_pred_taken", if_pred_taken, 0);
    cycle(1);

    // BR predicted to the wrong target
    id_valid = 1; id_instr = mk(OP_BR, 3'b111, 9'h0); id_pc = 16'h0030;
    id_pred_taken = 1; id_pred_target = 16'h0040; br_addr = 16'h0080;
    #1;
    chk("br_tgt_flush", flush, 1);
    cycle(1);
    chk("br_tgt_pc", if_pc, 16'h0080);

    // stall holds; stall with mispredict redirects
    idle(); stall = 1;
    go(1);
    go(1);
    chk("stall_hold_pc", if_pc, 16'h0080);
    id_valid = 1; id_instr = mk(OP_B, 3'b111, 9'h004); id_pc = 16'h0040;
    #1;
    chk("stall_misp_flush", flush, 1);
    cycle(1);
    chk("stall_misp_pc", if_pc, 16'h004A);

    // halt masks a mispredict completely
    idle(); halt = 1;
    id_valid = 1; id_instr = mk(OP_B, 3'b111, 9'h004); id_pc = 16'h0060;
    #1;
    chk("halt_flush", flush, 0);
    cycle(1);
    chk("halt_pc", if_pc, 16'h004A);
    chk("halt_cnt", mispredict_cnt, 32'(m_cnt));
    redirect_to(16'h0060);
    #1;
    chk("halt_no_alloc", if_pred_taken, 0);
    cycle(1);

    // condition-code table
    foreach (tbl[k]) begin
      idle();
      id_valid = 1; id_instr = mk(tbl[k].op, tbl[k].c, tbl[k].imm);
      id_pc = 16'h0100; br_addr = 16'h0200; flags = tbl[k].f;
      #1;
      chk("tbl_flush", flush, tbl[k].ef);
      cycle(1);
      if (tbl[k].ef) chk("tbl_pc", if_pc, tbl[k].epc);
    end

    // randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      rst      = ($urandom_range(0, 199) == 0);
      halt     = ($urandom_range(0, 19) == 0);
      stall    = ($urandom_range(0, 6) == 0);
      id_valid = ($urandom_range(0, 9) < 6);
      r  = int'($urandom_range(0, 9));
      op = (r < 4) ? OP_B : (r < 7) ? OP_BR : 4'($urandom);
      id_instr = {op, 3'($urandom), 9'($urandom)};
      id_pc    = 16'($urandom_range(0, 63)) << 1;
      br_addr  = 16'($urandom_range(0, 127)) << 1;
      flags    = 3'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        m_resolve(isb, tk, act);
        id_pred_taken  = tk;
        id_pred_target = tk ? 16'(act) : 16'($urandom);
      end else begin
        id_pred_taken  = 1'($urandom_range(0, 1));
        id_pred_target = 16'($urandom_range(0, 255)) << 1;
      end
      go(1);
    end

    // drive the mispredict counter into saturation
    idle();
    id_valid = 1; id_instr = mk(4'h0, 3'b000, 9'h0); id_pc = 16'h0100;
    id_pred_taken = 1; id_pred_target = 16'h0150;
    for (int i = 0; i < 70000 && m_cnt < 'hFFFF; i++) go(0);
    #1;
    chk("sat_cnt_reached", mispredict_cnt, 16'hFFFF);
    chk("sat_flush", flush, 1);
    cycle(1);
    chk("sat_cnt_hold", mispredict_cnt, 16'hFFFF);
    idle();
    go(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_predict_unit.md
# pc_predict_unit

Parametrised fetch-stage next-PC unit with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It owns the PC register and predicts the next fetch address every cycle. It resolves B and BR instructions in ID against the flags and register target, and issues a one-cycle flush plus redirect on misprediction. It sits between the instruction-memory address port and the IF/ID pipeline register.

## Interface
- `ADDR_W`, 16, PC/address width (even, ≥8)
- `INSTR_W`, 16, instruction width; opcode at [15:12], condition at [11:9], signed offset at [8:0]
- `BTB_ENTRIES`, 8, BTB depth (power of two, 2..64); IDX_W = log2(BTB_ENTRIES), TAG_W = ADDR_W-1-IDX_W
- `RESET_PC`, 0, PC value after reset
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `halt` in 1: freeze PC and all state
- `stall` in 1: hold PC (hazard stall); resolution still occurs
- `id_valid` in 1: ID holds a valid instruction this cycle (one pulse per instruction)
- `id_instr` in INSTR_W: instruction in ID
- `id_pc` in ADDR_W: PC of ID instruction
- `id_pred_taken` in 1, `id_pred_target` in ADDR_W: prediction carried through IF/ID
- `br_addr` in ADDR_W: register target for BR
- `flags` in 3: {Z,V,N}, valid whenever id_valid
- `if_pc` out ADDR_W: current fetch address (registered)
- `if_pred_taken` out 1, `if_pred_target` out ADDR_W: prediction for if_pc (combinational)
- `flush` out 1: squash instruction currently in IF
- `mispredict_cnt` out 16: saturating mispredict count

## Operation
- Lookup: idx = if_pc[IDX_W:1], tag = if_pc[ADDR_W-1:IDX_W+1]. Hit = valid[idx] & tag match. if_pred_taken = hit & ctr[idx][1]. if_pred_target = target[idx] when taken, otherwise if_pc+2.
- Resolution (id_valid): is_b = opcode 4'b1100, is_br = opcode 4'b1101. Condition codes C:
  - 000 ~Z; 001 Z; 010 ~(Z|N); 011 N; 100 ~N; 101 Z|N; 110 V; 111 always.
  - taken = (is_b|is_br) & cond.
  - Actual target: B is id_pc+2+(sext(I)<<1); BR is br_addr. All additions are modulo 2^ADDR_W.
  - mispredict = id_valid & ((taken != id_pred_taken) | (taken & id_pred_target != actual target)).
  - A non-branch predicted taken (aliasing) is a mispredict with taken=0.
- Next PC priority:
  - rst: RESET_PC.
  - halt: hold.
  - mispredict: taken ? actual target : id_pc+2.
  - stall: hold.
  - else: if_pred_target.
- flush = mispredict & ~halt. The pipeline guarantees that the squashed slot never raises id_valid, so two flushes never occur back to back.
- BTB update, on id_valid & (is_b|is_br) & ~halt, at idx/tag of id_pc:
  - hit, taken: ctr saturating +1 (max 3), target rewritten.
  - hit, not taken: ctr saturating −1 (min 0).
  - miss, taken: allocate with valid=1, tag, target, ctr=2'b10.
  - miss, not taken: no change.
  - A non-branch hit: clear valid.
- mispredict_cnt increments on flush and saturates at 16'hFFFF.

## Timing
- Reset values: if_pc=RESET_PC, all valid=0, all ctr=2'b01, mispredict_cnt=0. Hence if_pred_taken=0 and flush=0 in the reset cycle.
- Prediction is zero-latency (combinational from if_pc). Redirect applies at the edge ending the mispredict cycle, so the penalty is 1 cycle (1 squashed slot).
- flush is combinational, asserted in the same cycle as the mispredicting id_valid.
- Read-during-write at the same index: lookup sees pre-update contents; the update lands at the edge.
- rst mid-operation discards pending resolution; no BTB write occurs in a reset cycle.
- With stall and mispredict together, the redirect wins and the PC loads the corrected address.

## Configuration
- `PC_PREDICT_BTB_EN` defined: BTB and counters are built as above.
- Undefined: no BTB storage. if_pred_taken=0 and if_pred_target=if_pc+2 always (static not-taken). Every taken branch flushes. Resolution, flush and mispredict_cnt are unchanged.

## Structure
- Shared package:
  - opcode constants OP_B=4'b1100 and OP_BR=4'b1101
  - condition-code enum (NEQ, EQ, GT, LT, GTEQ, LTEQ, OVFL, ALWAYS)
  - flag bit positions Z=2, V=1, N=0
  - 2-bit counter constants
- One sub-module, `pc_btb`: the storage arrays, lookup port and update port, with synchronous reset of valid/ctr.
- Condition evaluation and next-PC mux stay in the top level.

## Test plan
- Reset, then 4 free-running cycles → if_pc = 0,2,4,6; flush=0; if_pred_taken=0.
- B at id_pc=0x0010, I=9'h004, C=111, id_pred_taken=0 → flush=1; if_pc=0x001A next cycle; BTB[idx 0] allocated with ctr=2'b10.
- Refetch of 0x0010 → if_pred_taken=1, if_pred_target=0x001A. Resolving taken gives no flush and ctr becomes 3.
- BR, C=001, Z=0, predicted taken → flush=1; if_pc=id_pc+2; ctr decremented.
- BR predicted taken to 0x0040 with br_addr=0x0080 → flush=1, if_pc=0x0080.
- stall=1 with no mispredict → if_pc holds. halt=1 during mispredict → if_pc holds, flush=0, BTB unchanged. mispredict_cnt at 0xFFFF stays at 0xFFFF.
